// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS control FSM.
//   - state encoding (state_e)
//   - opcode / funct constants of the supported instruction set
//   - AluOp, nPc_Sel, WaSel and WdSel code constants
//   - instr_t: one-hot instruction flags produced by mc_instr_decode
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_CMP  = 4'd3;
  localparam logic [3:0] ALU_LUI  = 4'd4;
  localparam logic [3:0] ALU_PASS = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_JAL  = 2'd1;
  localparam logic [1:0] NPC_GPR  = 2'd2;
  localparam logic [1:0] NPC_BR   = 2'd3;

  localparam logic [1:0] WA_RT    = 2'd0;
  localparam logic [1:0] WA_RD    = 2'd1;
  localparam logic [1:0] WA_RA    = 2'd2;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_MDR   = 2'd1;
  localparam logic [1:0] WD_PC    = 2'd2;

  typedef struct packed {
    logic addu;
    logic subu;
    logic sll;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
  } instr_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: unified memory port handshake between the control FSM
// (master) and the memory subsystem (slave).
//   mem_req   master->slave  access request
//   MemRead   master->slave  read access (fetch or lw)
//   MemWrite  master->slave  write access (sw)
//   IorD      master->slave  address select: 0 = PC, 1 = ALU result reg
//   mem_ready slave->master  access completes this cycle
interface mc_ctrl_fsm_if;
  logic mem_req;
  logic MemRead;
  logic MemWrite;
  logic IorD;
  logic mem_ready;

  modport master (output mem_req, output MemRead, output MemWrite,
                  output IorD, input mem_ready);
  modport slave  (input mem_req, input MemRead, input MemWrite,
                  input IorD, output mem_ready);
endinterface

// File: rtl/mc_instr_decode.sv
// mc_instr_decode: purely combinational decode of IR Op/Function into
// one-hot instruction flags, plus an illegal flag when nothing matches.
//   op     in  6   IR[31:26]
//   funct  in  6   IR[5:0]
//   instr  out     one-hot instr_t flags
//   illegal out 1  no supported instruction matched
module mc_instr_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output instr_t     instr,
  output logic       illegal
);

  logic rtype;

  assign rtype      = (op == OP_RTYPE);
  assign instr.addu = rtype && (funct == FN_ADDU);
  assign instr.subu = rtype && (funct == FN_SUBU);
  // sll with all-zero fields is the canonical nop; it decodes as sll
  assign instr.sll  = rtype && (funct == FN_SLL);
  assign instr.jr   = rtype && (funct == FN_JR);
  assign instr.ori  = (op == OP_ORI);
  assign instr.lui  = (op == OP_LUI);
  assign instr.lw   = (op == OP_LW);
  assign instr.sw   = (op == OP_SW);
  assign instr.beq  = (op == OP_BEQ);
  assign instr.jal  = (op == OP_JAL);
  assign illegal    = ~|instr;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) for the
// MIPS core, driving datapath strobes/selects and a unified memory port.
// Ports:
//   clk, reset_n (sync, active-low)
//   mem        mc_ctrl_fsm_if.master: mem_req/MemRead/MemWrite/IorD out,
//              mem_ready in
//   Op, Function, zero      decode and branch inputs
//   IrWrite, PcWrite, nPc_Sel, RegWrite, WaSel, WdSel, ExtOp, AluSrc,
//   AluOp                   datapath controls
//   bus_err, illegal_instr  one-cycle event pulses
// Parameter MEM_TIMEOUT: wait cycles before a memory access is aborted
// (0 disables the timeout).
// Optional macro MC_CTRL_PERF_CNT_EN adds cycle_cnt/instr_cnt outputs.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  mc_ctrl_fsm_if.master     mem,
  input  logic [5:0]        Op,
  input  logic [5:0]        Function,
  input  logic              zero,
  output logic              IrWrite,
  output logic              PcWrite,
  output logic [1:0]        nPc_Sel,
  output logic              RegWrite,
  output logic [1:0]        WaSel,
  output logic [1:0]        WdSel,
  output logic              ExtOp,
  output logic              AluSrc,
  output logic [3:0]        AluOp,
  output logic              bus_err,
  output logic              illegal_instr
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instr_cnt
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam bit TMO_EN = (MEM_TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  instr_t           ins;
  logic             ins_illegal;
  logic             access;
  logic             waiting;
  logic             timeout;

  mc_instr_decode u_dec (
    .op      (Op),
    .funct   (Function),
    .instr   (ins),
    .illegal (ins_illegal)
  );

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem.mem_req   = 1'b0;
    mem.MemRead   = 1'b0;
    mem.MemWrite  = 1'b0;
    mem.IorD      = 1'b0;
    IrWrite       = 1'b0;
    PcWrite       = 1'b0;
    nPc_Sel       = NPC_PC4;
    RegWrite      = 1'b0;
    WaSel         = WA_RT;
    WdSel         = WD_ALU;
    ExtOp         = 1'b0;
    AluSrc        = 1'b0;
    AluOp         = ALU_ADD;
    bus_err       = 1'b0;
    illegal_instr = 1'b0;

    access  = reset_n && ((state_q == S_FETCH) || (state_q == S_MEM));
    waiting = access && !mem.mem_ready;
    // Expires on the MEM_TIMEOUT-th consecutive wait cycle; a same-cycle
    // mem_ready is excluded by 'waiting', so completion wins.
    timeout = TMO_EN && waiting && (wait_cnt_q == CNT_LAST);

    if (reset_n) begin
      unique case (state_q)
        S_FETCH: begin
          // mem_req is withdrawn in the abort cycle; the read/address
          // selects stay as they were for the whole attempt.
          mem.mem_req = !timeout;
          mem.MemRead = 1'b1;
          if (mem.mem_ready) begin
            IrWrite = 1'b1;
            PcWrite = 1'b1;
            nPc_Sel = NPC_PC4;
            state_d = S_DECODE;
          end else if (timeout) begin
            bus_err = 1'b1;
          end
        end
        S_DECODE: begin
          if (ins.jal) begin
            PcWrite = 1'b1;
            nPc_Sel = NPC_JAL;
            state_d = S_WB;
          end else if (ins.jr) begin
            PcWrite = 1'b1;
            nPc_Sel = NPC_GPR;
            state_d = S_FETCH;
          end else if (ins_illegal) begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          state_d = S_WB;
          if (ins.subu) AluOp = ALU_SUB;
          if (ins.sll)  AluOp = ALU_SLL;
          if (ins.ori) begin
            AluOp  = ALU_OR;
            AluSrc = 1'b1;
          end
          if (ins.lui) begin
            AluOp  = ALU_LUI;
            AluSrc = 1'b1;
          end
          if (ins.lw || ins.sw) begin
            AluSrc  = 1'b1;
            ExtOp   = 1'b1;
            state_d = S_MEM;
          end
          if (ins.beq) begin
            AluOp   = ALU_CMP;
            ExtOp   = 1'b1;
            PcWrite = zero;
            nPc_Sel = zero ? NPC_BR : NPC_PC4;
            state_d = S_FETCH;
          end
        end
        S_MEM: begin
          mem.mem_req  = !timeout;
          mem.IorD     = 1'b1;
          mem.MemRead  = ins.lw;
          mem.MemWrite = ins.sw;
          if (mem.mem_ready) begin
            state_d = ins.lw ? S_WB : S_FETCH;
          end else if (timeout) begin
            bus_err = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          state_d  = S_FETCH;
          if (ins.addu || ins.subu || ins.sll) WaSel = WA_RD;
          if (ins.lw) WdSel = WD_MDR;
          if (ins.jal) begin
            WaSel = WA_RA;
            WdSel = WD_PC;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end

    // A fetch timeout stays in FETCH, so it must clear the counter itself.
    if ((state_d != state_q) || timeout) begin
      wait_cnt_d = '0;
    end else if (waiting) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        retire;

  always_comb begin
    // Retire = return to FETCH from a later state, except skipped
    // (illegal) instructions and aborted (timed-out) accesses.
    retire      = reset_n && (state_q != S_FETCH) && (state_d == S_FETCH) &&
                  !illegal_instr && !bus_err;
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    instr_cnt_d = instr_cnt_q + {31'd0, retire};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed bench for mc_ctrl_fsm. An instruction-level model
// expands each directed instruction (plus memory latencies and branch flag)
// into per-cycle input/expected-output records; one loop drives and checks.
module tb_mc_ctrl_fsm;

  localparam int TMO = 4;

  typedef enum int {I_ADDU, I_SUBU, I_SLL, I_ORI, I_LUI, I_LW, I_SW,
                    I_BEQ, I_JAL, I_JR, I_BAD} ik_e;

  typedef struct packed {
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic       mem_req;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       IrWrite;
    logic       PcWrite;
    logic [1:0] nPc_Sel;
    logic       RegWrite;
    logic [1:0] WaSel;
    logic [1:0] WdSel;
    logic       ExtOp;
    logic       AluSrc;
    logic [3:0] AluOp;
    logic       bus_err;
    logic       illegal_instr;
  } out_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] Op, Function;
  logic       zero;
  logic       IrWrite, PcWrite, RegWrite, ExtOp, AluSrc, bus_err, illegal_instr;
  logic [1:0] nPc_Sel, WaSel, WdSel;
  logic [3:0] AluOp;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mc_ctrl_fsm_if mif ();

  mc_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem           (mif),
    .Op            (Op),
    .Function      (Function),
    .zero          (zero),
    .IrWrite       (IrWrite),
    .PcWrite       (PcWrite),
    .nPc_Sel       (nPc_Sel),
    .RegWrite      (RegWrite),
    .WaSel         (WaSel),
    .WdSel         (WdSel),
    .ExtOp         (ExtOp),
    .AluSrc        (AluSrc),
    .AluOp         (AluOp),
    .bus_err       (bus_err),
    .illegal_instr (illegal_instr)
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    .cycle_cnt     (cycle_cnt),
    .instr_cnt     (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  in_t   in_q[$];
  out_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic void enc(input ik_e k, output logic [5:0] op, output logic [5:0] fn);
    op = 6'h00; fn = 6'h00;
    case (k)
      I_ADDU: fn = 6'h21;
      I_SUBU: fn = 6'h23;
      I_SLL:  fn = 6'h00;
      I_JR:   fn = 6'h08;
      I_ORI:  op = 6'h0D;
      I_LUI:  op = 6'h0F;
      I_LW:   op = 6'h23;
      I_SW:   op = 6'h2B;
      I_BEQ:  op = 6'h04;
      I_JAL:  op = 6'h03;
      default: fn = 6'h20;  // R-type add (trapping): not supported
    endcase
  endfunction

  task automatic push(input in_t i, input out_t o, input string t);
    in_q.push_back(i);
    exp_q.push_back(o);
    tag_q.push_back(t);
  endtask

  task automatic gen_reset(input int n);
    in_t i; out_t o;
    i.rst_n = 1'b0; i.op = 6'h23; i.fn = 6'h21; i.zero = 1'b1; i.rdy = 1'b1;
    o = '0;
    for (int c = 0; c < n; c++) push(i, o, "reset");
  endtask

  // fw/mw: wait cycles before mem_ready in fetch / memory phase.
  task automatic gen_instr(input ik_e k, input int fw, input int mw, input bit z);
    in_t i; out_t o;
    logic [5:0] op, fn;
    enc(k, op, fn);
    // fetch: IR not yet valid, so present an unsupported opcode
    for (int c = 0; ; c++) begin
      i.rst_n = 1'b1; i.op = 6'h3F; i.fn = 6'h3F; i.zero = 1'b1; i.rdy = (c >= fw);
      o = '0; o.mem_req = 1'b1; o.MemRead = 1'b1;
      if (c >= fw) begin
        o.IrWrite = 1'b1; o.PcWrite = 1'b1;
        push(i, o, "fetch");
        break;
      end
      if (c == TMO - 1) begin
        o.mem_req = 1'b0; o.bus_err = 1'b1;
        push(i, o, "fetch_tmo");
        return;
      end
      push(i, o, "fetch_wait");
    end
    // decode (mem_ready held high: must be ignored)
    i.op = op; i.fn = fn; i.rdy = 1'b1; i.zero = ~z;
    o = '0;
    if (k == I_JAL) begin o.PcWrite = 1'b1; o.nPc_Sel = 2'd1; end
    if (k == I_JR)  begin o.PcWrite = 1'b1; o.nPc_Sel = 2'd2; end
    if (k == I_BAD) o.illegal_instr = 1'b1;
    push(i, o, "decode");
    if (k == I_JR || k == I_BAD) return;
    if (k != I_JAL) begin
      i.zero = z;
      o = '0;
      case (k)
        I_SUBU: o.AluOp = 4'd1;
        I_SLL:  o.AluOp = 4'd6;
        I_ORI:  begin o.AluOp = 4'd2; o.AluSrc = 1'b1; end
        I_LUI:  begin o.AluOp = 4'd4; o.AluSrc = 1'b1; end
        I_LW, I_SW: begin o.AluSrc = 1'b1; o.ExtOp = 1'b1; end
        I_BEQ:  begin
          o.AluOp = 4'd3; o.ExtOp = 1'b1;
          if (z) begin o.PcWrite = 1'b1; o.nPc_Sel = 2'd3; end
        end
        default: o.AluOp = 4'd0;
      endcase
      push(i, o, "exec");
      if (k == I_BEQ) return;
      i.zero = ~z;
      if (k == I_LW || k == I_SW) begin
        for (int c = 0; ; c++) begin
          i.rdy = (c >= mw);
          o = '0; o.mem_req = 1'b1; o.IorD = 1'b1;
          o.MemRead = (k == I_LW); o.MemWrite = (k == I_SW);
          if (c >= mw) begin
            push(i, o, "mem");
            break;
          end
          if (c == TMO - 1) begin
            o.mem_req = 1'b0; o.bus_err = 1'b1;
            push(i, o, "mem_tmo");
            return;
          end
          push(i, o, "mem_wait");
        end
        if (k == I_SW) return;
      end
    end
    // write-back (mem_ready held low: must not matter)
    i.rdy = 1'b0;
    o = '0; o.RegWrite = 1'b1;
    if (k == I_ADDU || k == I_SUBU || k == I_SLL) o.WaSel = 2'd1;
    if (k == I_LW) o.WdSel = 2'd1;
    if (k == I_JAL) begin o.WaSel = 2'd2; o.WdSel = 2'd2; end
    push(i, o, "wb");
  endtask

  // Expand one instruction and pin the model's cycle count to a literal.
  task automatic run(input ik_e k, input int fw, input int mw, input bit z,
                     input int exp_len, input string name);
    int n0;
    n0 = in_q.size();
    gen_instr(k, fw, mw, z);
    checks++;
    if (in_q.size() - n0 != exp_len) begin
      errors++;
      $display("FAIL len_%s got=%0d required=%0d", name, in_q.size() - n0, exp_len);
    end
  endtask

  initial begin
    out_t act;
    in_t  cur;
    int   n0;
    reset_n = 1'b0; Op = '0; Function = '0; zero = 1'b0; mif.mem_ready = 1'b0;

    gen_reset(2);
    run(I_ADDU, 0, 0, 1'b0, 4, "addu");
    run(I_LW,   0, 3, 1'b0, 8, "lw_wait3");
    run(I_BEQ,  0, 0, 1'b1, 3, "beq_taken");
    run(I_BEQ,  0, 0, 1'b0, 3, "beq_not");
    run(I_JAL,  0, 0, 1'b0, 3, "jal");
    run(I_JR,   0, 0, 1'b0, 2, "jr");
    run(I_SUBU, 1, 0, 1'b0, 5, "subu_fw1");
    run(I_ORI,  0, 0, 1'b0, 4, "ori");
    run(I_LUI,  0, 0, 1'b0, 4, "lui");
    run(I_SLL,  0, 0, 1'b0, 4, "sll");
    run(I_SW,   0, 0, 1'b0, 4, "sw");
    run(I_BAD,  0, 0, 1'b0, 2, "illegal");
    run(I_ADDU, 9, 0, 1'b0, 4, "fetch_tmo");
    run(I_ADDU, 0, 0, 1'b0, 4, "addu_retry");
    run(I_SW,   0, 9, 1'b0, 7, "sw_tmo");
    run(I_LW,   0, 4, 1'b0, 7, "lw_tmo");
    // reset two cycles into an sw memory wait
    n0 = in_q.size();
    gen_instr(I_SW, 0, 9, 1'b0);
    while (in_q.size() > n0 + 5) begin
      void'(in_q.pop_back());
      void'(exp_q.pop_back());
      void'(tag_q.pop_back());
    end
    gen_reset(1);
    run(I_LW,   3, 0, 1'b0, 8, "lw_after_reset");
    run(I_ADDU, 0, 0, 1'b0, 4, "addu_last");

    for (int n = 0; n < in_q.size(); n++) begin
      @(posedge clk);
      #1;
      cur = in_q[n];
      reset_n = cur.rst_n; Op = cur.op; Function = cur.fn;
      zero = cur.zero; mif.mem_ready = cur.rdy;
      @(negedge clk);
      act.mem_req = mif.mem_req; act.MemRead = mif.MemRead;
      act.MemWrite = mif.MemWrite; act.IorD = mif.IorD;
      act.IrWrite = IrWrite; act.PcWrite = PcWrite; act.nPc_Sel = nPc_Sel;
      act.RegWrite = RegWrite; act.WaSel = WaSel; act.WdSel = WdSel;
      act.ExtOp = ExtOp; act.AluSrc = AluSrc; act.AluOp = AluOp;
      act.bus_err = bus_err; act.illegal_instr = illegal_instr;
      checks++;
      if (act !== exp_q[n]) begin
        errors++;
        $display("FAIL %s cycle=%0d got=%06h required=%06h", tag_q[n], n, act, exp_q[n]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
